// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Brief    : Shared AXI-Lite response codes used by the write-path blocks.
// Revision : 1.0 - initial release
// ============================================================================
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_wr_ext_q_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Brief    : Small synchronous FIFO. A push while full is accepted when a pop
//            happens in the same cycle. dout reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psh,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_val,
  output logic             full
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam logic [C_PTR_W-1:0] C_LAST = C_PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               w_do_psh;
  logic               w_do_pop;

  assign dout_val = (cnt_q != '0);
  assign full     = (cnt_q == C_CNT_W'(DEPTH));
  assign w_do_pop = pop && dout_val;
  assign w_do_psh = psh && (!full || w_do_pop);
  assign dout     = dout_val ? mem_q[rd_ptr_q] : '0;

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_do_psh) wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + C_PTR_W'(1);
    if (w_do_pop) rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + C_PTR_W'(1);
    case ({w_do_psh, w_do_pop})
      2'b10:   cnt_d = cnt_q + C_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - C_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_psh) mem_q[wr_ptr_q] <= din;
  end

endmodule : fifo
`default_nettype wire

// File: rtl/axil_wr_ext_q.sv
`default_nettype none
// ============================================================================
// Module   : axil_wr_ext_q
// Brief    : AXI-Lite write slave that queues in-window writes towards an
//            external write port and returns B responses either at accept
//            (posted) or on external completion (non-posted).
// Revision : 1.0 - initial release
// ============================================================================
module axil_wr_ext_q
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h10000000,
  parameter int                    MEM_SIZE   = 256,
  parameter int                    DEPTH      = 2,
  parameter int                    RSP_DEPTH  = 2,
  parameter int                    POSTED     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       axi_awaddr,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [DATA_WIDTH-1:0]       axi_wdata,
  input  logic [STRB_WIDTH-1:0]       axi_wstrb,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  output logic                        ext_wr_req,
  output logic [$clog2(MEM_SIZE)-1:0] ext_wr_addr,
  output logic [DATA_WIDTH-1:0]       ext_wr_dat,
  output logic [STRB_WIDTH-1:0]       ext_wen,
  input  logic                        ext_rsp_val,
  input  logic                        ext_rsp_err
);

  localparam int C_OFF_W = $clog2(MEM_SIZE);
  localparam int C_REQ_W = C_OFF_W + DATA_WIDTH + STRB_WIDTH;
  localparam int C_CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] C_WIN_MASK = ~ADDR_WIDTH'(MEM_SIZE - 1);

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [C_CNT_W-1:0]    resp_used_q, resp_used_d;

  logic               w_in_range;
  logic               w_rsp_ok;
  logic               w_fire_in;
  logic               w_fire_out;
  logic               w_fire;
  logic               w_req_full;
  logic               w_req_val;
  logic [C_REQ_W-1:0] w_req_dout;
  logic               w_ext_pop;
  logic               w_b_psh;
  logic [1:0]         w_b_din;
  logic               w_b_pop;
  logic               w_b_full;

  assign axi_awready = !aw_held_q;
  assign axi_wready  = !w_held_q;

  assign w_in_range = ((awaddr_q & C_WIN_MASK) == MEM_BASE);
  // The B-FIFO term is redundant with the credit count but keeps the queue
  // safe even if the credit accounting is ever changed.
  assign w_rsp_ok   = (resp_used_q < C_CNT_W'(RSP_DEPTH)) && (!w_b_full || w_b_pop);
  assign w_fire_in  = aw_held_q && w_held_q && w_in_range && !w_req_full && w_rsp_ok;
  // Non-posted error responses wait for the request queue to drain so that
  // B responses stay in pairing order.
  assign w_fire_out = aw_held_q && w_held_q && !w_in_range && w_rsp_ok &&
                      ((POSTED != 0) || !w_req_val);
  assign w_fire     = w_fire_in || w_fire_out;

  assign w_ext_pop  = ext_rsp_val && w_req_val;
  assign w_b_pop    = axi_bvalid && axi_bready;

  assign ext_wr_req = w_req_val;
  assign {ext_wr_addr, ext_wr_dat, ext_wen} = w_req_dout;

  // Select the B-queue push source for the configured response mode.
  always_comb begin
    w_b_psh = 1'b0;
    w_b_din = RESP_OKAY;
    if (POSTED != 0) begin
      w_b_psh = w_fire;
      w_b_din = w_fire_in ? RESP_OKAY : RESP_SLVERR;
    end else begin
      w_b_psh = w_fire_out || w_ext_pop;
      w_b_din = (w_fire_out || ext_rsp_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Next state of the AW/W holding registers and the response credit count.
  always_comb begin
    aw_held_d   = aw_held_q;
    awaddr_d    = awaddr_q;
    w_held_d    = w_held_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    resp_used_d = resp_used_q;
    if (w_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (axi_awvalid && !aw_held_q) begin
        aw_held_d = 1'b1;
        awaddr_d  = axi_awaddr;
      end
      if (axi_wvalid && !w_held_q) begin
        w_held_d = 1'b1;
        wdata_d  = axi_wdata;
        wstrb_d  = axi_wstrb;
      end
    end
    case ({w_fire, w_b_pop})
      2'b10:   resp_used_d = resp_used_q + C_CNT_W'(1);
      2'b01:   resp_used_d = resp_used_q - C_CNT_W'(1);
      default: resp_used_d = resp_used_q;
    endcase
  end

  // Holding registers and credit count; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q   <= 1'b0;
      awaddr_q    <= '0;
      w_held_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      resp_used_q <= '0;
    end else begin
      aw_held_q   <= aw_held_d;
      awaddr_q    <= awaddr_d;
      w_held_q    <= w_held_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      resp_used_q <= resp_used_d;
    end
  end

  fifo #(
    .WIDTH (C_REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .psh      (w_fire_in),
    .din      ({awaddr_q[C_OFF_W-1:0], wdata_q, wstrb_q}),
    .pop      (w_ext_pop),
    .dout     (w_req_dout),
    .dout_val (w_req_val),
    .full     (w_req_full)
  );

  fifo #(
    .WIDTH (2),
    .DEPTH (RSP_DEPTH)
  ) u_b_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .psh      (w_b_psh),
    .din      (w_b_din),
    .pop      (w_b_pop),
    .dout     (axi_bresp),
    .dout_val (axi_bvalid),
    .full     (w_b_full)
  );

endmodule : axil_wr_ext_q
`default_nettype wire

// File: tb/tb_axil_wr_ext_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_wr_ext_q
// Brief    : Self-checking bench for axil_wr_ext_q. Instance 0 is posted,
//            instance 1 is non-posted; both use the default window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_wr_ext_q;

  localparam logic [31:0] BASE = 32'h10000000;

  int tests = 0;
  int fails = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];
  logic        ext_wr_req [2];
  logic [7:0]  ext_wr_addr[2];
  logic [31:0] ext_wr_dat [2];
  logic [3:0]  ext_wen    [2];
  logic        ext_rsp_val[2];
  logic        ext_rsp_err[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axil_wr_ext_q #(.POSTED((g == 0) ? 1 : 0)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .axi_awaddr  (awaddr[g]),
      .axi_awvalid (awvalid[g]),
      .axi_awready (awready[g]),
      .axi_wdata   (wdata[g]),
      .axi_wstrb   (wstrb[g]),
      .axi_wvalid  (wvalid[g]),
      .axi_wready  (wready[g]),
      .axi_bresp   (bresp[g]),
      .axi_bvalid  (bvalid[g]),
      .axi_bready  (bready[g]),
      .ext_wr_req  (ext_wr_req[g]),
      .ext_wr_addr (ext_wr_addr[g]),
      .ext_wr_dat  (ext_wr_dat[g]),
      .ext_wen     (ext_wen[g]),
      .ext_rsp_val (ext_rsp_val[g]),
      .ext_rsp_err (ext_rsp_err[g])
    );
  end

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd256);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 3);
    if (k != 3) return BASE + 32'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) return 32'h10000100 + 32'($urandom_range(0, 255));
    return 32'h0FFFFF00 + 32'($urandom_range(0, 255));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      bready[d] = 1'b1; ext_rsp_val[d] = 1'b0; ext_rsp_err[d] = 1'b0;
    end
  endtask

  // Offer AW and W together and return in the cycle after both handshakes.
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                          input logic [3:0] s);
    bit ah, wh;
    awaddr[d] = a; wdata[d] = dat; wstrb[d] = s;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    for (int i = 0; i < 50 && (awvalid[d] || wvalid[d]); i++) begin
      ah = awvalid[d] && awready[d];
      wh = wvalid[d] && wready[d];
      tick();
      if (ah) awvalid[d] = 1'b0;
      if (wh) wvalid[d] = 1'b0;
    end
    tests++;
    if (awvalid[d] || wvalid[d]) begin
      fails++;
      $display("FAIL write_timeout dut%0d addr %h: aw pending %0b w pending %0b, required both accepted",
               d, a, awvalid[d], wvalid[d]);
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({awready[d], wready[d], bvalid[d], bresp[d], ext_wr_req[d]} !== 6'b110000) begin
        fails++;
        $display("FAIL reset_state dut%0d: got %b expected %b", d,
                 {awready[d], wready[d], bvalid[d], bresp[d], ext_wr_req[d]}, 6'b110000);
      end
    end
  endtask

  task automatic test_basic();
    idle_all();
    do_write(0, 32'h10000004, 32'hA5A5A5A5, 4'hF);
    tests++;
    if ({ext_wr_req[0], bvalid[0]} !== 2'b00) begin
      fails++; $display("FAIL basic_t1: req/bvalid got %b expected 00", {ext_wr_req[0], bvalid[0]});
    end
    tick();
    tests++;
    if ({ext_wr_req[0], ext_wr_addr[0], ext_wr_dat[0], ext_wen[0]} !== {1'b1, 8'h04, 32'hA5A5A5A5, 4'hF}) begin
      fails++; $display("FAIL basic_ext: got %b %h %h %h expected 1 04 a5a5a5a5 f",
                        ext_wr_req[0], ext_wr_addr[0], ext_wr_dat[0], ext_wen[0]);
    end
    tests++;
    if ({bvalid[0], bresp[0]} !== 3'b100) begin
      fails++; $display("FAIL basic_b: bvalid/bresp got %b expected 100", {bvalid[0], bresp[0]});
    end
    ext_rsp_val[0] = 1'b1;
    tick();
    ext_rsp_val[0] = 1'b0;
    tests++;
    if ({ext_wr_req[0], bvalid[0]} !== 2'b00) begin
      fails++; $display("FAIL basic_done: req/bvalid got %b expected 00", {ext_wr_req[0], bvalid[0]});
    end
  endtask

  task automatic test_w_first();
    idle_all();
    wdata[0] = 32'h12345678; wstrb[0] = 4'h3; wvalid[0] = 1'b1;
    tick();
    wvalid[0] = 1'b0;
    tests++;
    if (wready[0] !== 1'b0) begin
      fails++; $display("FAIL wfirst_wready: got %b expected 0", wready[0]);
    end
    tick(); tick();
    awaddr[0] = 32'h100000F0; awvalid[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    tests++;
    if (ext_wr_req[0] !== 1'b0) begin
      fails++; $display("FAIL wfirst_early: ext_wr_req got %b expected 0", ext_wr_req[0]);
    end
    tick();
    tests++;
    if ({ext_wr_req[0], ext_wr_addr[0], ext_wr_dat[0], ext_wen[0], awready[0], wready[0]} !==
        {1'b1, 8'hF0, 32'h12345678, 4'h3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL wfirst_ext: got %b %h %h %h %b%b expected 1 f0 12345678 3 11",
                        ext_wr_req[0], ext_wr_addr[0], ext_wr_dat[0], ext_wen[0], awready[0], wready[0]);
    end
    ext_rsp_val[0] = 1'b1;
    tick();
    ext_rsp_val[0] = 1'b0;
    tests++;
    if (ext_wr_req[0] !== 1'b0) begin
      fails++; $display("FAIL wfirst_single: ext_wr_req got %b expected 0", ext_wr_req[0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_oor();
    idle_all();
    do_write(0, 32'h20000000, 32'hDEADBEEF, 4'hF);
    tick();
    tests++;
    if ({bvalid[0], bresp[0], ext_wr_req[0]} !== 4'b1100) begin
      fails++; $display("FAIL oor_posted: bvalid/bresp/req got %b expected 1100",
                        {bvalid[0], bresp[0], ext_wr_req[0]});
    end
    tick();
    tests++;
    if ({bvalid[0], ext_wr_req[0]} !== 2'b00) begin
      fails++; $display("FAIL oor_posted_idle: got %b expected 00", {bvalid[0], ext_wr_req[0]});
    end
    do_write(1, 32'h10000010, 32'h00000001, 4'h1);
    do_write(1, 32'h20000000, 32'h00000002, 4'h1);
    repeat (4) tick();
    tests++;
    if ({bvalid[1], ext_wr_req[1]} !== 2'b01) begin
      fails++; $display("FAIL oor_np_wait: bvalid/req got %b expected 01", {bvalid[1], ext_wr_req[1]});
    end
    ext_rsp_val[1] = 1'b1;
    tick();
    ext_rsp_val[1] = 1'b0;
    tests++;
    if ({bvalid[1], bresp[1]} !== 3'b100) begin
      fails++; $display("FAIL oor_np_first: got %b expected 100", {bvalid[1], bresp[1]});
    end
    tick();
    tests++;
    if ({bvalid[1], bresp[1]} !== 3'b110) begin
      fails++; $display("FAIL oor_np_second: got %b expected 110", {bvalid[1], bresp[1]});
    end
    tick();
    tests++;
    if (bvalid[1] !== 1'b0) begin
      fails++; $display("FAIL oor_np_idle: bvalid got %b expected 0", bvalid[1]);
    end
  endtask

  task automatic test_full_req();
    logic [1:0] got[$];
    logic [1:0] exp_q[3];
    exp_q[0] = 2'b10; exp_q[1] = 2'b00; exp_q[2] = 2'b00;
    idle_all();
    do_write(1, 32'h10000000, 32'h11111111, 4'hF);
    do_write(1, 32'h10000004, 32'h22222222, 4'hF);
    do_write(1, 32'h10000008, 32'h33333333, 4'hF);
    repeat (3) tick();
    tests++;
    if ({awready[1], wready[1], ext_wr_req[1], ext_wr_addr[1]} !== {3'b001, 8'h00}) begin
      fails++; $display("FAIL full_held: got %b%b%b %h expected 001 00",
                        awready[1], wready[1], ext_wr_req[1], ext_wr_addr[1]);
    end
    ext_rsp_val[1] = 1'b1; ext_rsp_err[1] = 1'b1;
    tick();
    ext_rsp_val[1] = 1'b1; ext_rsp_err[1] = 1'b0;
    tests++;
    if ({bvalid[1], bresp[1]} !== 3'b110) begin
      fails++; $display("FAIL full_err_first: got %b expected 110", {bvalid[1], bresp[1]});
    end
    for (int i = 0; i < 30; i++) begin
      if (bvalid[1] && bready[1]) got.push_back(bresp[1]);
      tick();
    end
    ext_rsp_val[1] = 1'b0;
    tests++;
    if (got.size() != 3) begin
      fails++; $display("FAIL full_count: got %0d responses expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== exp_q[i]) begin
          fails++; $display("FAIL full_order[%0d]: got %b expected %b", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bp();
    int n;
    idle_all();
    bready[0] = 1'b0;
    do_write(0, 32'h10000020, 32'hAAAA0001, 4'hF);
    do_write(0, 32'h10000024, 32'hAAAA0002, 4'hF);
    do_write(0, 32'h10000028, 32'hAAAA0003, 4'hF);
    repeat (3) tick();
    tests++;
    if ({bvalid[0], bresp[0], awready[0], wready[0]} !== 5'b10000) begin
      fails++; $display("FAIL bp_held: got %b expected 10000", {bvalid[0], bresp[0], awready[0], wready[0]});
    end
    bready[0] = 1'b1; ext_rsp_val[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bvalid[0]) begin
        n++;
        tests++;
        if (bresp[0] !== 2'b00) begin
          fails++; $display("FAIL bp_resp[%0d]: got %b expected 00", n, bresp[0]);
        end
      end
      tick();
    end
    ext_rsp_val[0] = 1'b0;
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL bp_count: got %0d responses expected 3", n);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    idle_all();
    bready[1] = 1'b0;
    do_write(1, 32'h10000040, 32'h1, 4'hF);
    do_write(1, 32'h10000044, 32'h2, 4'hF);
    do_write(1, 32'h10000048, 32'h3, 4'hF);
    repeat (2) tick();
    tests++;
    if ({awready[1], ext_wr_req[1]} !== 2'b01) begin
      fails++; $display("FAIL rstmid_pre: awready/req got %b expected 01", {awready[1], ext_wr_req[1]});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({awready[1], wready[1], ext_wr_req[1], bvalid[1]} !== 4'b1100) begin
      fails++; $display("FAIL rstmid_post: got %b expected 1100",
                        {awready[1], wready[1], ext_wr_req[1], bvalid[1]});
    end
    bready[1] = 1'b1; ext_rsp_val[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bvalid[1] || ext_wr_req[1]) seen = 1'b1;
      tick();
    end
    ext_rsp_val[1] = 1'b0;
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rstmid_ghost: activity after reset got %b expected 0", seen);
    end
  endtask

  // Random traffic checked against a pairing-order model of the write path.
  task automatic test_random(input int d, input int ncyc);
    logic [31:0] awq[$];
    logic [35:0] wq[$];
    logic [31:0] pairq[$];
    logic [43:0] extq[$];
    bit          errq[$];
    bit aw_hs, w_hs, b_hs, e_pop, draining, done;
    logic [1:0]  exp_b;
    logic [31:0] a;
    logic [35:0] w;
    logic [43:0] e;
    int aw_tot, w_tot;
    idle_all();
    draining = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < ncyc + 400 && !done; cyc++) begin
      if (cyc == ncyc) draining = 1'b1;
      aw_hs = awvalid[d] && awready[d];
      w_hs  = wvalid[d] && wready[d];
      b_hs  = bvalid[d] && bready[d];
      e_pop = ext_rsp_val[d] && ext_wr_req[d];
      if (b_hs) begin
        tests++;
        if (pairq.size() == 0) begin
          fails++; $display("FAIL rnd%0d_b_extra: bresp %b with no write outstanding", d, bresp[d]);
        end else begin
          a = pairq.pop_front();
          if (!in_win(a)) exp_b = 2'b10;
          else if (d == 0) exp_b = 2'b00;
          else if (errq.size() == 0) exp_b = 2'b11;
          else exp_b = errq.pop_front() ? 2'b10 : 2'b00;
          if (bresp[d] !== exp_b) begin
            fails++; $display("FAIL rnd%0d_bresp addr %h: got %b expected %b", d, a, bresp[d], exp_b);
          end
        end
      end
      if (e_pop) begin
        tests++;
        if (extq.size() == 0) begin
          fails++; $display("FAIL rnd%0d_ext_extra: got request %h with none expected", d, ext_wr_addr[d]);
        end else begin
          e = extq.pop_front();
          if ({ext_wr_addr[d], ext_wr_dat[d], ext_wen[d]} !== e) begin
            fails++; $display("FAIL rnd%0d_ext: got %h expected %h", d,
                              {ext_wr_addr[d], ext_wr_dat[d], ext_wen[d]}, e);
          end
        end
        if (d == 1) errq.push_back(ext_rsp_err[d]);
      end
      if (aw_hs) awq.push_back(awaddr[d]);
      if (w_hs)  wq.push_back({wstrb[d], wdata[d]});
      while (awq.size() > 0 && wq.size() > 0) begin
        a = awq.pop_front();
        w = wq.pop_front();
        pairq.push_back(a);
        if (in_win(a)) extq.push_back({a[7:0], w[31:0], w[35:32]});
      end
      tick();
      if (!draining) begin
        if (aw_hs || !awvalid[d]) begin
          awvalid[d] = ($urandom_range(0, 2) != 0);
          awaddr[d]  = rand_addr();
        end
        if (w_hs || !wvalid[d]) begin
          wvalid[d] = ($urandom_range(0, 2) != 0);
          wdata[d]  = $urandom;
          wstrb[d]  = 4'($urandom);
        end
        bready[d]      = ($urandom_range(0, 3) != 0);
        ext_rsp_val[d] = ($urandom_range(0, 2) == 0);
        ext_rsp_err[d] = ($urandom_range(0, 1) == 1);
      end else begin
        if (aw_hs) awvalid[d] = 1'b0;
        if (w_hs)  wvalid[d]  = 1'b0;
        bready[d] = 1'b1;
        ext_rsp_val[d] = 1'b1;
        ext_rsp_err[d] = ($urandom_range(0, 1) == 1);
        aw_tot = awq.size() + (awvalid[d] ? 1 : 0);
        w_tot  = wq.size() + (wvalid[d] ? 1 : 0);
        if (aw_tot > w_tot && !wvalid[d]) begin
          wvalid[d] = 1'b1; wdata[d] = $urandom; wstrb[d] = 4'($urandom);
        end else if (w_tot > aw_tot && !awvalid[d]) begin
          awvalid[d] = 1'b1; awaddr[d] = rand_addr();
        end
        if (aw_tot == w_tot && !awvalid[d] && !wvalid[d] && pairq.size() == 0 && extq.size() == 0)
          done = 1'b1;
      end
    end
    ext_rsp_val[d] = 1'b0;
    tests++;
    if (pairq.size() != 0 || extq.size() != 0) begin
      fails++; $display("FAIL rnd%0d_drain: %0d responses and %0d requests still pending, expected 0",
                        d, pairq.size(), extq.size());
    end
    tick();
    tests++;
    if ({bvalid[d], ext_wr_req[d]} !== 2'b00) begin
      fails++; $display("FAIL rnd%0d_idle: bvalid/req got %b expected 00", d, {bvalid[d], ext_wr_req[d]});
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_w_first();
    test_oor();
    test_full_req();
    test_bp();
    test_reset_mid();
    test_random(0, 800);
    test_random(1, 800);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_axil_wr_ext_q
`default_nettype wire
